// File: rtl/nonce_scan.sv
// nonce_scan: streams NUM_NONCES final-hash H0 words from the shared word
// memory, tracks the smallest one (lowest index wins on ties), compares it
// against a latched difficulty target and writes a two-word result record.
//
// Timing is fixed by an edge counter started at the accepting start edge
// (edge 0). The memory is synchronous with one register stage, so a word whose
// address is registered at edge k is sampled by this block at edge k+2.

module nonce_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [15:0] best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Controller states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WR0   = 3'd3;
  localparam logic [2:0] S_WR1   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Key edge numbers, counted from the start edge (edge 0)
  localparam logic [16:0] LAST_ISSUE  = 17'(NUM_NONCES - 1);
  localparam logic [16:0] FIRST_SAMPLE = 17'd2;
  localparam logic [16:0] LAST_SAMPLE = 17'(NUM_NONCES + 1);
  localparam logic [16:0] WR0_EDGE    = 17'(NUM_NONCES + 2);

  logic [2:0]  r_state;
  logic [16:0] r_edge;
  logic [15:0] r_hashBase;
  logic [15:0] r_resultBase;
  logic [31:0] r_target;
  logic        r_done;
  logic        r_found;
  logic [15:0] r_bestNonce;
  logic [31:0] r_bestHash;
  logic        r_memWe;
  logic [15:0] r_memAddr;
  logic [31:0] r_memWdata;

  logic        w_idleLike;
  logic        w_startAccept;
  logic        w_scanning;
  logic        w_issue;
  logic        w_sample;
  logic        w_firstSample;
  logic        w_finalSample;
  logic [15:0] w_sampleIdx;
  logic        w_takeWord;
  logic [31:0] w_nextBestHash;
  logic        w_wr0;
  logic        w_wr1;
  logic        w_finish;

  // The memory runs on the same clock as the scanner
  assign mem_clk = clk;

  // start is only honoured when no scan is in flight
  assign w_idleLike    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_startAccept = start && w_idleLike;

  // Address issue happens on READ edges 1..NUM_NONCES-1 (edge 0 issues word 0)
  assign w_scanning = (r_state == S_READ) || (r_state == S_DRAIN);
  assign w_issue    = (r_state == S_READ) && (r_edge <= LAST_ISSUE);

  // Word i arrives at edge i+2; samples may occur in READ as well as DRAIN
  assign w_sample      = w_scanning && (r_edge >= FIRST_SAMPLE) && (r_edge <= LAST_SAMPLE);
  assign w_firstSample = w_sample && (r_edge == FIRST_SAMPLE);
  assign w_finalSample = w_sample && (r_edge == LAST_SAMPLE);
  assign w_sampleIdx   = r_edge[15:0] - 16'd2;

  // Word 0 always loads; later words only when strictly smaller (unsigned)
  assign w_takeWord     = w_sample && (w_firstSample || (mem_read_data < r_bestHash));
  assign w_nextBestHash = w_takeWord ? mem_read_data : r_bestHash;

  // Result write phases
  assign w_wr0    = (r_state == S_DRAIN) && (r_edge == WR0_EDGE);
  assign w_wr1    = (r_state == S_WR0);
  assign w_finish = (r_state == S_WR1);

  // State sequencing and the edge counter that paces the fixed-latency scan
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_edge  <= 17'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_READ;
            r_edge  <= 17'd1;
          end
        end
        S_READ: begin
          r_edge <= r_edge + 17'd1;
          if (r_edge >= LAST_ISSUE) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_edge <= r_edge + 17'd1;
          if (r_edge == WR0_EDGE) begin
            r_state <= S_WR0;
          end
        end
        S_WR0: begin
          r_edge  <= r_edge + 17'd1;
          r_state <= S_WR1;
        end
        S_WR1: begin
          r_edge  <= 17'd0;
          r_state <= S_DONE;
        end
        default: begin
          r_edge  <= 17'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Capture scan parameters at start so mid-scan input changes have no effect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hashBase   <= 16'd0;
      r_resultBase <= 16'd0;
      r_target     <= 32'd0;
    end else if (w_startAccept) begin
      r_hashBase   <= hash_addr;
      r_resultBase <= result_addr;
      r_target     <= target;
    end
  end

  // Running minimum, found flag and completion flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_bestNonce <= 16'd0;
      r_bestHash  <= 32'd0;
    end else if (w_startAccept) begin
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_bestNonce <= 16'd0;
      r_bestHash  <= 32'd0;
    end else begin
      if (w_takeWord) begin
        r_bestHash  <= mem_read_data;
        r_bestNonce <= w_sampleIdx;
      end
      if (w_finalSample) begin
        r_found <= (w_nextBestHash < r_target);
      end
      if (w_finish) begin
        r_done <= 1'b1;
      end
    end
  end

  // Registered memory port: hash reads during the scan, then two result writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memWe    <= 1'b0;
      r_memAddr  <= 16'd0;
      r_memWdata <= 32'd0;
    end else if (w_startAccept) begin
      r_memWe   <= 1'b0;
      r_memAddr <= hash_addr;
    end else if (w_issue) begin
      r_memWe   <= 1'b0;
      r_memAddr <= r_hashBase + r_edge[15:0];
    end else if (w_wr0) begin
      r_memWe    <= 1'b1;
      r_memAddr  <= r_resultBase;
      r_memWdata <= {r_found, 15'd0, r_bestNonce};
    end else if (w_wr1) begin
      r_memWe    <= 1'b1;
      r_memAddr  <= r_resultBase + 16'd1;
      r_memWdata <= r_bestHash;
    end else if (w_finish) begin
      r_memWe <= 1'b0;
    end
  end

  assign done           = r_done;
  assign found          = r_found;
  assign best_nonce     = r_bestNonce;
  assign best_hash      = r_bestHash;
  assign mem_we         = r_memWe;
  assign mem_addr       = r_memAddr;
  assign mem_write_data = r_memWdata;

endmodule

// File: tb/tb_nonce_scan.sv
// Testbench for nonce_scan: a synchronous word memory model, a queue-based
// reference model of the minimum search, and one task per scenario.

module tb_nonce_scan;

  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] hashAddr;
  logic [15:0] resultAddr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [15:0] bestNonce;
  logic [31:0] bestHash;
  logic        memClk;
  logic        memWe;
  logic [15:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  logic [31:0] tbMem [0:65535];
  logic [47:0] wrLog [$];

  int errors = 0;
  int checks = 0;

  nonce_scan #(.NUM_NONCES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .hash_addr     (hashAddr),
    .result_addr   (resultAddr),
    .target        (target),
    .done          (done),
    .found         (found),
    .best_nonce    (bestNonce),
    .best_hash     (bestHash),
    .mem_clk       (memClk),
    .mem_we        (memWe),
    .mem_addr      (memAddr),
    .mem_write_data(memWdata),
    .mem_read_data (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory with one read register; logs every write
  always @(posedge memClk) begin
    if (memWe) begin
      tbMem[memAddr] <= memWdata;
      wrLog.push_back({memAddr, memWdata});
    end
    memRdata <= tbMem[memAddr];
  end

  // Reference: the minimum of the words and the first index holding it
  task automatic model_scan(input logic [15:0] hb, input logic [31:0] tg,
                            output logic eFound, output logic [15:0] eNonce,
                            output logic [31:0] eHash);
    logic [31:0] words [$];
    logic [31:0] minQ [$];
    int idxQ [$];
    for (int i = 0; i < N; i++) words.push_back(tbMem[16'(hb + 16'(i))]);
    minQ   = words.min();
    eHash  = minQ[0];
    idxQ   = words.find_first_index(x) with (x == eHash);
    eNonce = 16'(idxQ[0]);
    eFound = (eHash < tg);
  endtask

  // Pulse start for one edge and count edges until done is seen (bounded)
  task automatic run_scan(input logic [15:0] hb, input logic [15:0] rb,
                          input logic [31:0] tg, output int cycles);
    wrLog.delete();
    @(negedge clk);
    hashAddr = hb; resultAddr = rb; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL reset_found: got %b expected 0", found); end
    checks++; if (bestNonce !== 16'd0) begin errors++; $display("[TB] FAIL reset_nonce: got %h expected 0", bestNonce); end
    checks++; if (bestHash !== 32'd0) begin errors++; $display("[TB] FAIL reset_hash: got %h expected 0", bestHash); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", memWe); end
    checks++; if (memAddr !== 16'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", memAddr); end
    checks++; if (memWdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", memWdata); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_descending;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h1000 + 16'(i)] = 32'hFFFF0000 - 32'(i);
    model_scan(16'h1000, 32'h0000FFFF, eF, eN, eH);
    run_scan(16'h1000, 16'h2000, 32'h0000FFFF, cyc);
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL desc_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (found !== eF) begin errors++; $display("[TB] FAIL desc_found: got %b expected %b", found, eF); end
    checks++; if (bestNonce !== eN) begin errors++; $display("[TB] FAIL desc_nonce: got %h expected %h", bestNonce, eN); end
    checks++; if (bestHash !== eH) begin errors++; $display("[TB] FAIL desc_hash: got %h expected %h", bestHash, eH); end
    checks++; if (wrLog.size() != 2) begin errors++; $display("[TB] FAIL desc_wrcount: got %0d expected 2", wrLog.size()); end
    checks++; if (wrLog[0] !== {16'h2000, eF, 15'd0, eN}) begin errors++; $display("[TB] FAIL desc_wr0: got %h expected %h", wrLog[0], {16'h2000, eF, 15'd0, eN}); end
    checks++; if (wrLog[1] !== {16'h2001, eH}) begin errors++; $display("[TB] FAIL desc_wr1: got %h expected %h", wrLog[1], {16'h2001, eH}); end
  endtask

  task automatic test_single_winner;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h3000 + 16'(i)] = (i == 5) ? 32'h00000123 : 32'h80000000;
    model_scan(16'h3000, 32'h00001000, eF, eN, eH);
    wrLog.delete();
    @(negedge clk);
    hashAddr = 16'h3000; resultAddr = 16'h3100; target = 32'h00001000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Changing the inputs mid-scan must not disturb the latched values
    target = 32'd0; hashAddr = 16'h0000; resultAddr = 16'h0000;
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (found !== eF) begin errors++; $display("[TB] FAIL single_found: got %b expected %b", found, eF); end
    checks++; if (bestNonce !== eN) begin errors++; $display("[TB] FAIL single_nonce: got %h expected %h", bestNonce, eN); end
    checks++; if (wrLog[0] !== {16'h3100, eF, 15'd0, eN}) begin errors++; $display("[TB] FAIL single_wr0: got %h expected %h", wrLog[0], {16'h3100, eF, 15'd0, eN}); end
    checks++; if (wrLog[1] !== {16'h3101, eH}) begin errors++; $display("[TB] FAIL single_wr1: got %h expected %h", wrLog[1], {16'h3101, eH}); end
  endtask

  task automatic test_tie;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h4000 + 16'(i)] = (i == 3 || i == 9) ? 32'h00000010 : 32'hFFFFFFFF;
    model_scan(16'h4000, 32'h00000010, eF, eN, eH);
    run_scan(16'h4000, 16'h4100, 32'h00000010, cyc);
    checks++; if (bestNonce !== eN) begin errors++; $display("[TB] FAIL tie_nonce: got %h expected %h", bestNonce, eN); end
    checks++; if (found !== eF) begin errors++; $display("[TB] FAIL tie_found: got %b expected %b", found, eF); end
    checks++; if (bestHash !== eH) begin errors++; $display("[TB] FAIL tie_hash: got %h expected %h", bestHash, eH); end
  endtask

  task automatic test_wrap;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    logic [15:0] base;
    base = 16'hFFF8;
    for (int i = 0; i < N; i++) tbMem[16'(base + 16'(i))] = $urandom;
    model_scan(base, 32'hFFFFFFFF, eF, eN, eH);
    wrLog.delete();
    @(negedge clk);
    hashAddr = base; resultAddr = 16'h5000; target = 32'hFFFFFFFF; start = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (memAddr !== 16'(base + 16'(k)) || memWe !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_read%0d: got addr %h we %b expected addr %h we 0", k, memAddr, memWe, 16'(base + 16'(k)));
      end
    end
    cyc = -1;
    for (int k = N; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (bestHash !== eH || bestNonce !== eN) begin errors++; $display("[TB] FAIL wrap_best: got %h/%h expected %h/%h", bestNonce, bestHash, eN, eH); end
  endtask

  task automatic test_target_zero;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h6000 + 16'(i)] = (i == 7) ? 32'd0 : $urandom;
    model_scan(16'h6000, 32'd0, eF, eN, eH);
    run_scan(16'h6000, 16'h6100, 32'd0, cyc);
    checks++; if (found !== eF) begin errors++; $display("[TB] FAIL tz_found: got %b expected %b", found, eF); end
    checks++; if (wrLog.size() != 2) begin errors++; $display("[TB] FAIL tz_wrcount: got %0d expected 2", wrLog.size()); end
    checks++; if (wrLog[1] !== {16'h6101, eH}) begin errors++; $display("[TB] FAIL tz_wr1: got %h expected %h", wrLog[1], {16'h6101, eH}); end
  endtask

  task automatic test_reset_at_wr0;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h7000 + 16'(i)] = $urandom_range(1000, 1);
    wrLog.delete();
    @(negedge clk);
    hashAddr = 16'h7000; resultAddr = 16'h7100; target = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 1) @(negedge clk);
    // Reset and start together at the WR0 edge: reset must win
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL rwr0_we: got %b expected 0", memWe); end
    checks++; if (bestHash !== 32'd0) begin errors++; $display("[TB] FAIL rwr0_hash: got %h expected 0", bestHash); end
    repeat (30) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rwr0_done: got %b expected 0", done); end
    checks++; if (wrLog.size() != 0) begin errors++; $display("[TB] FAIL rwr0_writes: got %0d expected 0", wrLog.size()); end
    model_scan(16'h7000, 32'd500, eF, eN, eH);
    run_scan(16'h7000, 16'h7100, 32'd500, cyc);
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL rwr0_rescan_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (wrLog[0] !== {16'h7100, eF, 15'd0, eN}) begin errors++; $display("[TB] FAIL rwr0_rescan_wr0: got %h expected %h", wrLog[0], {16'h7100, eF, 15'd0, eN}); end
    checks++; if (wrLog[1] !== {16'h7101, eH}) begin errors++; $display("[TB] FAIL rwr0_rescan_wr1: got %h expected %h", wrLog[1], {16'h7101, eH}); end
  endtask

  task automatic test_restart;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    for (int i = 0; i < N; i++) tbMem[16'h8000 + 16'(i)] = $urandom;
    for (int i = 0; i < N; i++) tbMem[16'h9000 + 16'(i)] = $urandom;
    model_scan(16'h8000, 32'h40000000, eF, eN, eH);
    wrLog.delete();
    @(negedge clk);
    hashAddr = 16'h8000; resultAddr = 16'h8100; target = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      start = (k == 5);
      if (k == 5) hashAddr = 16'h9000;
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    start = 1'b0;
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL restart_ignored_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (bestHash !== eH || bestNonce !== eN) begin errors++; $display("[TB] FAIL restart_first_best: got %h/%h expected %h/%h", bestNonce, bestHash, eN, eH); end
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1 || found !== eF || bestHash !== eH) begin errors++; $display("[TB] FAIL restart_hold: got %b/%b/%h expected 1/%b/%h", done, found, bestHash, eF, eH); end
    model_scan(16'h9000, 32'h40000000, eF, eN, eH);
    wrLog.delete();
    hashAddr = 16'h9000; resultAddr = 16'h9100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL restart_done_clear: got %b expected 0", done); end
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
    checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected %0d", cyc, N + 4); end
    checks++; if (wrLog[0] !== {16'h9100, eF, 15'd0, eN}) begin errors++; $display("[TB] FAIL restart_wr0: got %h expected %h", wrLog[0], {16'h9100, eF, 15'd0, eN}); end
    checks++; if (wrLog[1] !== {16'h9101, eH}) begin errors++; $display("[TB] FAIL restart_wr1: got %h expected %h", wrLog[1], {16'h9101, eH}); end
  endtask

  task automatic test_random;
    logic eF; logic [15:0] eN; logic [31:0] eH; int cyc;
    logic [15:0] hb;
    logic [31:0] tg;
    int mode;
    for (int t = 0; t < 12; t++) begin
      hb = 16'($urandom);
      mode = $urandom_range(2, 0);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: tbMem[16'(hb + 16'(i))] = $urandom;
          1: tbMem[16'(hb + 16'(i))] = $urandom_range(7, 0);
          default: tbMem[16'(hb + 16'(i))] = ($urandom_range(5, 0) == 0) ? $urandom_range(300, 0) : 32'hFFFFFFFF;
        endcase
      end
      model_scan(hb, 32'd0, eF, eN, eH);
      case ($urandom_range(3, 0))
        0: tg = $urandom;
        1: tg = eH;
        2: tg = eH + 32'd1;
        default: tg = 32'd0;
      endcase
      model_scan(hb, tg, eF, eN, eH);
      run_scan(hb, 16'(hb + 16'h8000), tg, cyc);
      checks++; if (cyc != N + 4) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", t, cyc, N + 4); end
      checks++; if (found !== eF || bestNonce !== eN || bestHash !== eH) begin errors++; $display("[TB] FAIL rand%0d_result: got %b/%h/%h expected %b/%h/%h", t, found, bestNonce, bestHash, eF, eN, eH); end
      checks++;
      if (wrLog.size() != 2 || wrLog[0] !== {16'(hb + 16'h8000), eF, 15'd0, eN} || wrLog[1] !== {16'(hb + 16'h8001), eH}) begin
        errors++;
        $display("[TB] FAIL rand%0d_writes: got %0d writes %h %h expected 2 writes %h %h", t, wrLog.size(), wrLog[0], wrLog[1],
                 {16'(hb + 16'h8000), eF, 15'd0, eN}, {16'(hb + 16'h8001), eH});
      end
    end
  endtask

  // Run the scenarios in sequence, then report
  initial begin
    reset = 1'b1; start = 1'b0;
    hashAddr = 16'd0; resultAddr = 16'd0; target = 32'd0;
    for (int a = 0; a < 65536; a++) tbMem[a] = 32'd0;
    test_reset();
    test_descending();
    test_single_winner();
    test_tie();
    test_wrap();
    test_target_zero();
    test_reset_at_wr0();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
